// File: rtl/pmem_line_responder_pkg.sv
// Shared types for the pmem line responder.
//   lc3b_word / lc3b_8word : 16-bit address word and 128-bit line.
//   PMEM_LINE_OFFSET_BITS  : byte-offset bits inside a line (ignored by the array).
//   pmem_resp_state_t      : responder FSM states.
package pmem_line_responder_pkg;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_8word;

  localparam int PMEM_LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_resp_state_t;
endpackage

// File: rtl/pmem_line_responder_array.sv
// pmem_line_array: DEPTH_LINES x 128-bit line store, one synchronous port.
// Ports:
//   clk, rst : clock; rst clears only the read register, never the contents
//   en, we   : access strobe and write select
//   idx      : line index
//   wdata    : line to write
//   rdata    : registered read line; updated only by reads, held otherwise
module pmem_line_array
  import pmem_line_responder_pkg::*;
#(
  parameter int DEPTH_LINES = 4096,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  lc3b_8word        wdata,
  output lc3b_8word        rdata
);
  lc3b_8word mem [DEPTH_LINES];

  always_ff @(posedge clk)
    if (en && we) mem[idx] <= wdata;

  // Output register only moves on reads, so the last read line stays visible.
  always_ff @(posedge clk)
    if (rst)              rdata <= '0;
    else if (en && !we)   rdata <= mem[idx];
endmodule

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: fixed-latency line memory on mp3's pmem_* interface.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pmem_read/write   : request strobes, held by initiator until pmem_resp
//   pmem_address      : byte address; low PMEM_LINE_OFFSET_BITS ignored
//   pmem_wdata        : write line
//   pmem_resp         : one-cycle completion pulse
//   pmem_rdata        : read line, valid at resp, held until next read completes
//   pmem_err          : sticky protocol error flag
// Optional feature: define PMEM_PROTOCOL_CHECK_EN to build the protocol checker;
// otherwise pmem_err is tied low.
module pmem_line_responder
  import pmem_line_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_BYTES  = 16,
  parameter int DEPTH_LINES = 4096,
  parameter int LATENCY     = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  lc3b_8word             pmem_wdata,
  output logic                  pmem_resp,
  output lc3b_8word             pmem_rdata,
  output logic                  pmem_err
);
  localparam int          IDX_W    = $clog2(DEPTH_LINES);
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  pmem_resp_state_t state, nstate;
  logic [7:0]            cnt;
  logic                  lat_read, lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  lc3b_8word             lat_wdata;
  logic                  req, access;

  assign req = pmem_read | pmem_write;

  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= nstate;

  // next state
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (req) nstate = BUSY;
      BUSY:    if (cnt == 8'd0) nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // outputs; the array access happens on the edge that enters RESP
  always_comb begin
    pmem_resp = (state == RESP);
    access    = (state == BUSY) && (cnt == 8'd0);
  end

  always_ff @(posedge clk)
    if (rst)                              cnt <= '0;
    else if (state == IDLE && req)        cnt <= CNT_LOAD;
    else if (state == BUSY && cnt != 8'd0) cnt <= cnt - 8'd1;

  // Request latches: no reset needed, only consumed after a fresh capture.
  always_ff @(posedge clk)
    if (state == IDLE && req) begin
      lat_read  <= pmem_read;
      lat_write <= pmem_write;
      lat_addr  <= pmem_address;
      lat_wdata <= pmem_wdata;
    end

  // write wins when both strobes are high
  pmem_line_array #(.DEPTH_LINES(DEPTH_LINES), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (access),
    .we    (lat_write),
    .idx   (lat_addr[PMEM_LINE_OFFSET_BITS +: IDX_W]),
    .wdata (lat_wdata),
    .rdata (pmem_rdata)
  );

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic viol;
  always_comb begin
    viol = 1'b0;
    if (state == IDLE && pmem_read && pmem_write) viol = 1'b1;
    if (state == BUSY && (pmem_read != lat_read || pmem_write != lat_write ||
                          pmem_address != lat_addr ||
                          (lat_write && pmem_wdata != lat_wdata)))
      viol = 1'b1;
  end

  always_ff @(posedge clk)
    if (rst)       pmem_err <= 1'b0;
    else if (viol) pmem_err <= 1'b1;

`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!rst && viol) $error("pmem protocol violation in state %s", state.name());
`endif

  logic unused;
  assign unused = ^{pmem_address, lat_addr, LINE_BYTES[0]};
`else
  assign pmem_err = 1'b0;

  logic unused;
  assign unused = ^{pmem_address, lat_addr, lat_read, LINE_BYTES[0]};
`endif
endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench: instance 0 uses LATENCY=4 / 4096 lines, instance 1 uses
// LATENCY=1 / 16 lines for the index-wrap case. Inputs change on negedge,
// outputs sampled on negedge.
module tb_pmem_line_responder;
  import pmem_line_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd   [2];
  logic        wr   [2];
  lc3b_word    addr [2];
  lc3b_8word   wd   [2];
  logic        resp [2];
  lc3b_8word   rdat [2];
  logic        err  [2];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pmem_line_responder #(.LATENCY(4), .DEPTH_LINES(4096)) dut0 (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wd[0]),
    .pmem_resp(resp[0]), .pmem_rdata(rdat[0]), .pmem_err(err[0]));

  pmem_line_responder #(.LATENCY(1), .DEPTH_LINES(16)) dut1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wd[1]),
    .pmem_resp(resp[1]), .pmem_rdata(rdat[1]), .pmem_err(err[1]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

`ifdef PMEM_PROTOCOL_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  localparam lc3b_8word W1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam lc3b_8word W2 = 128'hDEADBEEF_00112233_44556677_8899AABB;
  localparam lc3b_8word WC = 128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_C0C0C0C0;
  localparam lc3b_8word WD = 128'hD1D1D1D1_D1D1D1D1_D1D1D1D1_D1D1D1D1;
  localparam lc3b_8word W5 = 128'h5555AAAA_5555AAAA_12345678_9ABCDEF0;
  localparam lc3b_8word WA = 128'hAAAA0000_AAAA0000_AAAA0000_AAAA000F;
  localparam lc3b_8word WB = 128'hBBBB1111_BBBB1111_BBBB1111_BBBB1110;

  // One idle cycle, then present a request and count negedges until resp.
  // Leaves the request dropped on the resp negedge.
  task automatic req(input int s, input logic r, input logic w,
                     input lc3b_word a, input lc3b_8word d, output int cyc);
    @(negedge clk);
    rd[s] = r; wr[s] = w; addr[s] = a; wd[s] = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (resp[s] !== 1'b1 && cyc < 100);
    rd[s] = 1'b0; wr[s] = 1'b0;
  endtask

  initial begin
    int c, gap, hits;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b1; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    rst = 1'b1;

    // 1: reset with read held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_resp",  resp[0], 1'b0);
      chk("rst_rdata", rdat[0], 128'h0);
      chk("rst_err",   err[0],  1'b0);
    end
    rd[0] = 1'b0; rd[1] = 1'b0;
    rst = 1'b0;

    // 2: write then read, LATENCY=4 -> resp on the 5th cycle
    req(0, 1'b0, 1'b1, 16'h0040, W1, c);
    chk("wr_latency", c, 5);
    chk("wr_rdata_unchanged", rdat[0], 128'h0);
    @(negedge clk);
    chk("resp_width", resp[0], 1'b0);
    req(0, 1'b0, 1'b1, 16'h0050, W2, c);
    chk("wr2_latency", c, 5);
    req(0, 1'b1, 1'b0, 16'h004A, 128'h0, c);
    chk("rd_latency", c, 5);
    chk("rd_data", rdat[0], W1);

    // 3: back-to-back reads; second is sampled in the IDLE cycle after RESP,
    // so pulses are separated by LATENCY+2 edges
    @(negedge clk);
    rd[0] = 1'b1; addr[0] = 16'h0040;
    c = 0;
    do begin @(negedge clk); c++; end while (resp[0] !== 1'b1 && c < 100);
    chk("b2b_first_latency", c, 5);
    chk("b2b_first_data", rdat[0], W1);
    addr[0] = 16'h0050;
    gap = 0;
    do begin @(negedge clk); gap++; end while (resp[0] !== 1'b1 && gap < 100);
    rd[0] = 1'b0;
    chk("b2b_gap", gap, 6);
    chk("b2b_second_data", rdat[0], W2);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp[0] === 1'b1) hits++;
    end
    chk("b2b_no_dup", hits, 0);

    // 4: reset mid-BUSY discards a pending write
    req(0, 1'b0, 1'b1, 16'h0060, WC, c);
    chk("wr60_latency", c, 5);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 16'h0060; wd[0] = WD;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_resp", resp[0], 1'b0);
    rst = 1'b0; wr[0] = 1'b0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp[0] === 1'b1) hits++;
    end
    chk("abort_no_resp", hits, 0);
    req(0, 1'b1, 1'b0, 16'h0060, 128'h0, c);
    chk("abort_old_data", rdat[0], WC);

    // 5: read & write together -> write performed
    req(0, 1'b1, 1'b1, 16'h0070, W5, c);
    chk("both_latency", c, 5);
    chk("both_rdata_unchanged", rdat[0], WC);
    chk("both_err", err[0], ERR_EXP);
    req(0, 1'b1, 1'b0, 16'h0070, 128'h0, c);
    chk("both_written", rdat[0], W5);
    chk("both_err_sticky", err[0], ERR_EXP);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", err[0], 1'b0);

    // 6: LATENCY=1, 16 lines; 0xFFF0 -> index 15, 0x0100 aliases 0x0000
    req(1, 1'b0, 1'b1, 16'hFFF0, WA, c);
    chk("l1_wr_latency", c, 2);
    req(1, 1'b0, 1'b1, 16'h0000, WB, c);
    chk("l1_wr0_latency", c, 2);
    req(1, 1'b1, 1'b0, 16'h0100, 128'h0, c);
    chk("wrap_alias", rdat[1], WB);
    req(1, 1'b1, 1'b0, 16'hFFF0, 128'h0, c);
    chk("l1_rd_latency", c, 2);
    chk("wrap_top", rdat[1], WA);
    req(1, 1'b1, 1'b0, 16'h0000, 128'h0, c);
    chk("wrap_zero", rdat[1], WB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
